// File: rtl/subleq_ctrl.sv
// Sequencer for the 8-bit SUBLEQ machine: fetches a/b/c, writes mem[b]-mem[a] back, branches if <= 0.
// Optional macro SUBLEQ_HALT_EN adds a HALT state entered on a taken branch to 8'hFF.
module subleq_ctrl (
    input  logic       clk,
    input  logic       res,
    input  logic       run,
    output logic       instr_done,
    output logic       halted,
    input  logic [7:0] pc_val,
    output logic [1:0] pc_mod,
    output logic [7:0] pc_inp,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);

    localparam logic [1:0] PcHold = 2'd0;
    localparam logic [1:0] PcInc  = 2'd1;
    localparam logic [1:0] PcLoad = 2'd2;

    typedef enum logic [3:0] {
        StInit,
        StFetchA,
        StFetchB,
        StFetchC,
        StReadA,
        StReadB,
        StWriteB,
        StBranch
`ifdef SUBLEQ_HALT_EN
        , StHalt
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ra_q, ra_d;
    logic [7:0] rb_q, rb_d;
    logic [7:0] rc_q, rc_d;
    logic [7:0] va_q, va_d;
    logic [7:0] vb_q, vb_d;
    // Keeps an unacknowledged FETCH_A request alive even if run drops during wait states.
    logic       pend_q, pend_d;

    logic [7:0] diff;
    logic       leq;

    assign diff = vb_q - va_q;
    assign leq  = diff[7] | (diff == 8'h00);

    always_comb begin
        state_d    = state_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        va_d       = va_q;
        vb_d       = vb_q;
        pend_d     = 1'b0;
        pc_mod     = PcHold;
        pc_inp     = rc_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 8'h00;
        instr_done = 1'b0;

        case (state_q)
            StInit: begin
                pc_mod  = PcLoad;
                pc_inp  = 8'h00;
                state_d = StFetchA;
            end
            StFetchA: begin
                if (run || pend_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_val;
                    if (mem_ack) begin
                        ra_d    = mem_rdata;
                        pc_mod  = PcInc;
                        state_d = StFetchB;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            StFetchB: begin
                mem_req  = 1'b1;
                mem_addr = pc_val;
                if (mem_ack) begin
                    rb_d    = mem_rdata;
                    pc_mod  = PcInc;
                    state_d = StFetchC;
                end
            end
            StFetchC: begin
                mem_req  = 1'b1;
                mem_addr = pc_val;
                if (mem_ack) begin
                    rc_d    = mem_rdata;
                    pc_mod  = PcInc;
                    state_d = StReadA;
                end
            end
            StReadA: begin
                mem_req  = 1'b1;
                mem_addr = ra_q;
                if (mem_ack) begin
                    va_d    = mem_rdata;
                    state_d = StReadB;
                end
            end
            StReadB: begin
                mem_req  = 1'b1;
                mem_addr = rb_q;
                if (mem_ack) begin
                    vb_d    = mem_rdata;
                    state_d = StWriteB;
                end
            end
            StWriteB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = rb_q;
                mem_wdata = diff;
                if (mem_ack) begin
                    state_d = StBranch;
                end
            end
            StBranch: begin
                instr_done = 1'b1;
                if (leq) begin
                    pc_mod = PcLoad;
                end
                state_d = StFetchA;
`ifdef SUBLEQ_HALT_EN
                if (leq && (rc_q == 8'hFF)) begin
                    state_d = StHalt;
                end
`endif
            end
`ifdef SUBLEQ_HALT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StInit;
            ra_q    <= 8'h00;
            rb_q    <= 8'h00;
            rc_q    <= 8'h00;
            va_q    <= 8'h00;
            vb_q    <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            pend_q  <= pend_d;
        end
    end

`ifdef SUBLEQ_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// Scoreboard bench for subleq_ctrl with a PC register model and a wait-state memory model.
// Honours SUBLEQ_HALT_EN when checking the branch-to-FF behaviour.
module tb_subleq_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       run = 1'b0;
    logic       instr_done;
    logic       halted;
    logic [7:0] pc_val;
    logic [1:0] pc_mod;
    logic [7:0] pc_inp;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    logic [7:0]  mem [256];
    logic [7:0]  pc_q     = 8'h55;
    int unsigned nwait    = 0;
    int unsigned wait_cnt = 0;
    int unsigned wr_cnt   = 0;
    logic [7:0]  wr_addr  = 8'h00;
    logic [7:0]  wr_data  = 8'h00;
    int          total    = 0;
    int          bad      = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] pc;
        int         cycles;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    subleq_ctrl dut (
        .clk        (clk),
        .res        (res),
        .run        (run),
        .instr_done (instr_done),
        .halted     (halted),
        .pc_val     (pc_val),
        .pc_mod     (pc_mod),
        .pc_inp     (pc_inp),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    assign pc_val    = pc_q;
    assign mem_ack   = mem_req && (wait_cnt == nwait);
    assign mem_rdata = mem_ack ? mem[mem_addr] : 8'hA5;

    // PC register and memory responder; writes are logged rather than stored.
    always @(posedge clk) begin
        case (pc_mod)
            2'd1:    pc_q <= pc_q + 8'd1;
            2'd2:    pc_q <= pc_inp;
            default: pc_q <= pc_q;
        endcase
        if (mem_req && mem_ack) begin
            wait_cnt <= 0;
            if (mem_we) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic load_instr(input logic [7:0] pc, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] va, input logic [7:0] vb,
                              input bit push);
        logic [7:0] p1, p2, d;
        exp_t e;
        p1 = pc + 8'd1;
        p2 = pc + 8'd2;
        mem[pc] = a;
        mem[p1] = b;
        mem[p2] = c;
        mem[a]  = va;
        mem[b]  = vb;
        d = vb - va;
        e.addr   = b;
        e.data   = d;
        e.pc     = ($signed(d) <= 0) ? c : pc + 8'd3;
        e.cycles = 7 + 6 * int'(nwait);
        if (push) exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
    endtask

    task automatic exec_one(input string name, input bit drop_run);
        exp_t        e;
        int          cycles;
        int unsigned w0;
        bit          done;
        bit          pend;
        logic [7:0]  pa, pw;
        logic        pwe;
        w0 = wr_cnt;
        @(negedge clk);
        run = 1'b1;
        #1;
        cycles = 0;
        done = 1'b0;
        pend = 1'b0;
        pa = 8'h00;
        pw = 8'h00;
        pwe = 1'b0;
        while (!done && cycles < 200) begin
            cycles++;
            if (pend) begin
                total++;
                if (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pwe || mem_wdata !== pw) begin
                    bad++;
                    $display("FAIL %s hold: req=%b addr=%h we=%b wdata=%h required 1 %h %b %h",
                             name, mem_req, mem_addr, mem_we, mem_wdata, pa, pwe, pw);
                end
            end
            pend = mem_req && !mem_ack;
            pa = mem_addr;
            pwe = mem_we;
            pw = mem_wdata;
            if (drop_run && cycles == 2) run = 1'b0;
            if (instr_done === 1'b1) done = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        run = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: no instr_done within %0d cycles", name, cycles);
        end
        e = exp_q.pop_front();
        total++;
        if (cycles != e.cycles) begin
            bad++;
            $display("FAIL %s cycles: got %0d required %0d", name, cycles, e.cycles);
        end
        @(negedge clk);
        #1;
        total++;
        if (instr_done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse: got %b required 0", name, instr_done);
        end
        total++;
        if (wr_cnt - w0 != 1) begin
            bad++;
            $display("FAIL %s write_count: got %0d required 1", name, wr_cnt - w0);
        end
        total++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
            bad++;
            $display("FAIL %s write: got [%h]=%h required [%h]=%h",
                     name, wr_addr, wr_data, e.addr, e.data);
        end
        total++;
        if (pc_q !== e.pc) begin
            bad++;
            $display("FAIL %s pc: got %h required %h", name, pc_q, e.pc);
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (pc_mod !== 2'd2 || pc_inp !== 8'h00) begin
            bad++;
            $display("FAIL reset_pc: got mod=%0d inp=%h required 2 00", pc_mod, pc_inp);
        end
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, instr_done, halted} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outs: got req=%b we=%b addr=%h wdata=%h done=%b halted=%b required 0",
                     mem_req, mem_we, mem_addr, mem_wdata, instr_done, halted);
        end
        @(negedge clk);
        total++;
        if (pc_q !== 8'h00) begin
            bad++;
            $display("FAIL reset_pcload: got %h required 00", pc_q);
        end
        res = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL init_cycle_req: got %b required 0", mem_req);
        end
        @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL first_fetch: got req=%b addr=%h required 1 00", mem_req, mem_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'd3, 8'd5, 1'b1);
        exec_one("basic", 1'b0);
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'd5, 8'd5, 1'b1);
        exec_one("zero_branch", 1'b0);
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'h01, 8'h80, 1'b1);
        exec_one("signed_pos", 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'd3, 8'd5, 1'b1);
        load_instr(8'h03, 8'h20, 8'h21, 8'h40, 8'd9, 8'd4, 1'b1);
        load_instr(8'h40, 8'h22, 8'h22, 8'h10, 8'd7, 8'd7, 1'b1);
        exec_one("b2b_0", 1'b0);
        exec_one("b2b_neg", 1'b0);
        exec_one("b2b_alias_rundrop", 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'hFE, 8'd5, 8'd5, 1'b1);
        load_instr(8'hFE, 8'h30, 8'h31, 8'h10, 8'd1, 8'd2, 1'b1);
        exec_one("wrap_jump", 1'b0);
        exec_one("wrap_fetch", 1'b0);
    endtask

    task automatic test_wait_states();
        do_reset();
        nwait = 2;
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'd3, 8'd5, 1'b1);
        exec_one("wait2", 1'b0);
        nwait = 0;
    endtask

    task automatic test_res_write();
        int unsigned w0;
        bit          found;
        do_reset();
        nwait = 2;
        load_instr(8'h00, 8'h10, 8'h11, 8'h06, 8'd3, 8'd5, 1'b0);
        @(negedge clk);
        run = 1'b1;
        #1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem_we === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL res_write_reach: got no write request required one");
        end
        w0 = wr_cnt;
        res = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b0 || pc_mod !== 2'd2) begin
            bad++;
            $display("FAIL res_abort: got req=%b mod=%0d required 0 2", mem_req, pc_mod);
        end
        @(negedge clk);
        #1;
        total++;
        if (wr_cnt != w0) begin
            bad++;
            $display("FAIL res_nowrite: got %0d writes required 0", wr_cnt - w0);
        end
        total++;
        if (pc_q !== 8'h00) begin
            bad++;
            $display("FAIL res_pc: got %h required 00", pc_q);
        end
        res = 1'b0;
        run = 1'b0;
        nwait = 0;
        @(negedge clk);
    endtask

    task automatic test_run_gate();
        int reqs;
        do_reset();
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (mem_req !== 1'b0) reqs++;
        end
        total++;
        if (reqs != 0) begin
            bad++;
            $display("FAIL run_gate_idle: got %0d request cycles required 0", reqs);
        end
        run = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL run_gate_start: got req=%b addr=%h required 1 00", mem_req, mem_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_halt();
        int reqs;
        do_reset();
        load_instr(8'h00, 8'h10, 8'h11, 8'hFF, 8'd5, 8'd5, 1'b1);
        exec_one("branch_ff", 1'b0);
`ifdef SUBLEQ_HALT_EN
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_flag: got %b required 1", halted);
        end
        run = 1'b1;
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (mem_req !== 1'b0) reqs++;
        end
        total++;
        if (reqs != 0 || pc_q !== 8'hFF) begin
            bad++;
            $display("FAIL halt_idle: got reqs=%0d pc=%h required 0 ff", reqs, pc_q);
        end
`else
        reqs = 0;
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_tied: got %b required 0", halted);
        end
        run = 1'b1;
        #1;
        if (mem_req !== 1'b1) reqs++;
        total++;
        if (reqs != 0 || mem_addr !== 8'hFF) begin
            bad++;
            $display("FAIL ff_fetch: got req=%b addr=%h required 1 ff", mem_req, mem_addr);
        end
`endif
        run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_wait_states();
        test_res_write();
        test_run_gate();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
